regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//   Debug read-out engine for the register file. On a start pulse it walks
//   register indices lo..hi and drives each index onto a spare regfile read port.
//   It samples each returned word and streams it out on a valid/ready channel
//   tagged with index and last flag. It sits beside the core's register file,
//   owns one read-address port, and never writes the register file.
// PARAMETERS
//   N        32  register / data width, must match the register file
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst_n      in   1   synchronous reset, active low
//   start      in   1   begin dump; sampled only in IDLE
//   lo_idx     in   5   first register index, captured on accepted start
//   hi_idx     in   5   last register index, captured on accepted start
//   abort      in   1   cancel dump in any state
//   rf_addr    out  5   read address to register file port
//   rf_data    in   N   combinational read data from register file
//   out_valid  out  1   out_data/out_idx/out_last valid
//   out_ready  in   1   consumer accepts word when out_valid&&out_ready
//   out_data   out  N   sampled register value
//   out_idx    out  5   index of out_data
//   out_last   out  1   out_idx == captured hi
//   busy       out  1   state != IDLE
//   done       out  1   one-cycle pulse, dump completed normally
//   err        out  1   one-cycle pulse, start rejected because lo_idx > hi_idx
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, idx=0, rf_addr=0, out_valid=0,
//     out_data=0, out_idx=0, out_last=0, busy=0, done=0, err=0. Reset wins over all.
//   States: IDLE, READ, HOLD, DONE.
//   IDLE:  rf_addr=0. start && lo<=hi -> capture lo,hi; idx=lo; goto READ.
//          start && lo>hi -> err=1 for one cycle, stay IDLE.
//   READ:  rf_addr=idx; at the edge, out_data<=rf_data, out_idx<=idx,
//          out_last<=(idx==hi), out_valid<=1; goto HOLD.
//   HOLD:  outputs held stable while out_valid && !out_ready.
//          On handshake: out_valid<=0; if out_last goto DONE, else idx<=idx+1,
//          goto READ.
//   DONE:  done=1 for exactly one cycle; goto IDLE.
//   Latency: start accepted at edge k -> out_valid=1 after edge k+1.
//     Max rate is one word per 2 cycles. Zero-wait consumer takes words after
//     edges k+1, k+3, ...
//   Snapshot: a word is sampled in READ. Later regfile writes to that index do not
//     alter the held out_data. Regfile writes land on the falling edge, so a write
//     in the same cycle as READ is visible in the sampled word.
//   x0 is read like any index. The regfile returns 0 for it.
//   lo==hi: a single word with out_last=1.
//   hi=31: idx stops at 31 and never wraps to 0.
//   abort: at the next edge go to IDLE, out_valid=0, no done.
//     abort overrides start and handshake in the same cycle.
//   start while busy: ignored, lo/hi not recaptured.
//   out_valid never drops without a handshake, except on abort or reset.
// TESTING
//   1 lo=0,hi=31, out_ready=1, regs[i]=i*0x11 -> 32 words, out_idx 0..31,
//     x0 data 0, out_last only on idx 31, done pulse once, busy low after.
//   2 lo=5,hi=7, out_ready low 3 cycles on each word -> data/idx stable while
//     stalled, exactly 3 words, values regs[5..7].
//   3 lo=9,hi=9, write regs[9]=0xDEADBEEF in the READ cycle, then 0x1234 during
//     HOLD -> out_data=0xDEADBEEF, out_last=1.
//   4 lo=8,hi=3 -> err pulse 1 cycle, busy stays 0, out_valid never asserts.
//   5 lo=0,hi=31, abort after 4th handshake -> out_valid=0 next cycle, no done,
//     new start lo=30,hi=31 yields idx 30,31.
//   6 rst_n low mid-HOLD -> all outputs at reset values next edge. start during
//     busy is ignored (hi unchanged).

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Output stream channel of the register-file dump reader.
//   out_valid  : out_data/out_idx/out_last are valid
//   out_ready  : consumer accepts the word when out_valid && out_ready
//   out_data   : sampled register value
//   out_idx    : register index of out_data
//   out_last   : out_idx is the final index of the dump
// master = dump reader (producer), slave = consumer.
interface regfile_dump_reader_if #(
  parameter int unsigned N = 32
);
  localparam int unsigned IDX_W = 5;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: on start, walks register indices lo..hi through a
// spare regfile read port and streams each sampled word out with its index
// and a last flag. Never writes the register file.
//   clk, rst_n      : clock, synchronous active-low reset
//   start_i         : begin dump (sampled only while idle)
//   lo_idx_i/hi_idx_i : index range, captured on accepted start
//   abort_i         : cancel dump in any state
//   rf_addr_o       : regfile read address
//   rf_data_i       : combinational regfile read data
//   out_if          : valid/ready output stream (master side)
//   busy_o          : dump in progress
//   done_o          : one-cycle pulse on normal completion
//   err_o           : one-cycle pulse when start rejected (lo > hi)
module regfile_dump_reader #(
  parameter int unsigned N = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [4:0]                lo_idx_i,
  input  logic [4:0]                hi_idx_i,
  input  logic                      abort_i,
  output logic [4:0]                rf_addr_o,
  input  logic [N-1:0]              rf_data_i,
  regfile_dump_reader_if.master     out_if,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [IDX_W-1:0] hi_q,       hi_d;
  logic [IDX_W-1:0] rf_addr_q,  rf_addr_d;
  logic             valid_q,    valid_d;
  logic [N-1:0]     data_q,     data_d;
  logic [IDX_W-1:0] oidx_q,     oidx_d;
  logic             last_q,     last_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hi_q      <= '0;
      rf_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      oidx_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      rf_addr_q <= rf_addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      oidx_q    <= oidx_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (lo_idx_i <= hi_idx_i) begin
            idx_d   = lo_idx_i;
            hi_d    = hi_idx_i;
            state_d = READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READ: begin
        data_d  = rf_data_i;
        oidx_d  = idx_q;
        last_d  = (idx_q == hi_q);
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          // Last word ends the walk before idx can wrap past 31.
          if (last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = IDX_W'(idx_q + 5'd1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort beats start and handshake in the same cycle.
    if (abort_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end

    // Address is registered, so it is computed from the upcoming state/index.
    rf_addr_d = (state_d == IDLE) ? '0 : idx_d;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign rf_addr_o        = rf_addr_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = oidx_q;
  assign out_if.out_last  = last_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed testbench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [4:0]   lo_idx;
  logic [4:0]   hi_idx;
  logic [4:0]   rf_addr;
  logic [N-1:0] rf_data;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] regs [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_dump_reader_if #(.N(N)) out_if ();

  // Register file read port: x0 always reads as zero.
  assign rf_data = (rf_addr == 5'd0) ? '0 : regs[rf_addr];

  regfile_dump_reader #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .lo_idx_i  (lo_idx),
    .hi_idx_i  (hi_idx),
    .abort_i   (abort),
    .rf_addr_o (rf_addr),
    .rf_data_i (rf_data),
    .out_if    (out_if),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  function automatic logic [N-1:0] exp_val(input int i);
    if (i == 0) return '0;
    return N'(i * 32'h11);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags valid=%b busy=%b done=%b err=%b want all 0",
               out_if.out_valid, busy, done, err);
    end
    n_cmp++;
    if (out_if.out_data !== '0 || out_if.out_idx !== 5'd0 || out_if.out_last !== 1'b0 || rf_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_bus data=%h idx=%0d last=%b addr=%0d want 0",
               out_if.out_data, out_if.out_idx, out_if.out_last, rf_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full();
    int w = 0;
    int dones = 0;
    start = 1'b1; lo_idx = 5'd0; hi_idx = 5'd31; out_if.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        n_cmp++;
        if (out_if.out_valid !== 1'b0 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL full_first_cycle valid=%b busy=%b want 0/1", out_if.out_valid, busy);
        end
      end
      if (done === 1'b1) dones++;
      if (out_if.out_valid === 1'b1) begin
        n_cmp++;
        if (cyc != 2 + 2 * w) begin
          n_bad++;
          $display("FAIL full_timing word=%0d at cycle %0d want %0d", w, cyc, 2 + 2 * w);
        end
        n_cmp++;
        if (out_if.out_data !== exp_val(w) || out_if.out_idx !== 5'(w) || out_if.out_last !== (w == 31)) begin
          n_bad++;
          $display("FAIL full_word w=%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   w, out_if.out_data, out_if.out_idx, out_if.out_last, exp_val(w), w, (w == 31));
        end
        w++;
      end
    end
    n_cmp++;
    if (w != 32 || dones != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL full_end words=%0d dones=%0d busy=%b want 32/1/0", w, dones, busy);
    end
  endtask

  task automatic test_stall();
    int w = 0;
    int seen = 0;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; lo_idx = 5'd5; hi_idx = 5'd7; out_if.out_ready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (out_if.out_valid === 1'b1) begin
        n_cmp++;
        if (out_if.out_data !== exp_val(5 + w) || out_if.out_idx !== 5'(5 + w) || out_if.out_last !== (w == 2)) begin
          n_bad++;
          $display("FAIL stall_word w=%0d stall=%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   w, seen, out_if.out_data, out_if.out_idx, out_if.out_last, exp_val(5 + w), 5 + w, (w == 2));
        end
        if (seen < 3) begin
          seen++;
          out_if.out_ready = 1'b0;
        end else begin
          seen = 0;
          out_if.out_ready = 1'b1;
          w++;
        end
      end else begin
        out_if.out_ready = 1'b0;
      end
    end
    n_cmp++;
    if (w != 3 || dones != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_end words=%0d dones=%0d busy=%b want 3/1/0", w, dones, busy);
    end
  endtask

  task automatic test_snapshot();
    @(negedge clk);
    regs[9] = 32'h0BAD_0BAD;
    start = 1'b1; lo_idx = 5'd9; hi_idx = 5'd9; out_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (rf_addr !== 5'd9) begin
      n_bad++;
      $display("FAIL snap_addr got %0d want 9", rf_addr);
    end
    regs[9] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (out_if.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL snap_valid got %b want 1", out_if.out_valid);
    end
    regs[9] = 32'h0000_1234;
    @(negedge clk);
    n_cmp++;
    if (out_if.out_data !== 32'hDEAD_BEEF || out_if.out_idx !== 5'd9 || out_if.out_last !== 1'b1) begin
      n_bad++;
      $display("FAIL snap_word got data=%h idx=%0d last=%b want deadbeef/9/1",
               out_if.out_data, out_if.out_idx, out_if.out_last);
    end
    out_if.out_ready = 1'b1;
    @(negedge clk);
    out_if.out_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || out_if.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL snap_done done=%b valid=%b want 1/0", done, out_if.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL snap_idle done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_err();
    logic seen_bad = 1'b0;
    start = 1'b1; lo_idx = 5'd8; hi_idx = 5'd3;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || out_if.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse err=%b busy=%b valid=%b want 1/0/0", err, busy, out_if.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_one_cycle err=%b want 0", err);
    end
    repeat (5) begin
      @(negedge clk);
      if (out_if.out_valid !== 1'b0 || busy !== 1'b0) seen_bad = 1'b1;
    end
    n_cmp++;
    if (seen_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL err_quiet saw valid/busy activity=%b want 0", seen_bad);
    end
  endtask

  task automatic test_abort();
    int hs = 0;
    int w = 0;
    int dones = 0;
    logic seen_bad = 1'b0;
    start = 1'b1; lo_idx = 5'd0; hi_idx = 5'd31; out_if.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 30 && hs < 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_if.out_valid === 1'b1) begin
        n_cmp++;
        if (out_if.out_idx !== 5'(hs)) begin
          n_bad++;
          $display("FAIL abort_pre_idx got %0d want %0d", out_if.out_idx, hs);
        end
        hs++;
      end
    end
    n_cmp++;
    if (hs != 4) begin
      n_bad++;
      $display("FAIL abort_pre_count got %0d want 4", hs);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || rf_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL abort_idle valid=%b busy=%b addr=%0d want 0/0/0", out_if.out_valid, busy, rf_addr);
    end
    repeat (5) begin
      @(negedge clk);
      if (out_if.out_valid !== 1'b0 || done !== 1'b0) seen_bad = 1'b1;
    end
    n_cmp++;
    if (seen_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet saw valid/done after abort=%b want 0", seen_bad);
    end
    start = 1'b1; lo_idx = 5'd30; hi_idx = 5'd31;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (out_if.out_valid === 1'b1) begin
        n_cmp++;
        if (out_if.out_data !== exp_val(30 + w) || out_if.out_idx !== 5'(30 + w) || out_if.out_last !== (w == 1)) begin
          n_bad++;
          $display("FAIL abort_restart w=%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   w, out_if.out_data, out_if.out_idx, out_if.out_last, exp_val(30 + w), 30 + w, (w == 1));
        end
        w++;
      end
    end
    n_cmp++;
    if (w != 2 || dones != 1) begin
      n_bad++;
      $display("FAIL abort_restart_end words=%0d dones=%0d want 2/1", w, dones);
    end
  endtask

  task automatic test_busy_start_and_reset();
    int w = 0;
    start = 1'b1; lo_idx = 5'd2; hi_idx = 5'd4; out_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; lo_idx = 5'd0; hi_idx = 5'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (out_if.out_valid !== 1'b1 || out_if.out_idx !== 5'd2) begin
      n_bad++;
      $display("FAIL busy_start_hold valid=%b idx=%0d want 1/2", out_if.out_valid, out_if.out_idx);
    end
    out_if.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (out_if.out_valid === 1'b1) begin
        n_cmp++;
        if (out_if.out_idx !== 5'(2 + w) || out_if.out_data !== exp_val(2 + w) || out_if.out_last !== (w == 2)) begin
          n_bad++;
          $display("FAIL busy_start_word w=%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                   w, out_if.out_idx, out_if.out_data, out_if.out_last, 2 + w, exp_val(2 + w), (w == 2));
        end
        w++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (w != 3 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_end words=%0d busy=%b want 3/0", w, busy);
    end
    out_if.out_ready = 1'b0;
    start = 1'b1; lo_idx = 5'd10; hi_idx = 5'd12;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_if.out_valid !== 1'b1 || out_if.out_idx !== 5'd10) begin
      n_bad++;
      $display("FAIL rst_pre valid=%b idx=%0d want 1/10", out_if.out_valid, out_if.out_idx);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_if.out_valid !== 1'b0 || out_if.out_data !== '0 || out_if.out_idx !== 5'd0 ||
        out_if.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rf_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL rst_mid valid=%b data=%h idx=%0d last=%b busy=%b done=%b err=%b addr=%0d want all 0",
               out_if.out_valid, out_if.out_data, out_if.out_idx, out_if.out_last, busy, done, err, rf_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_if.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after valid=%b busy=%b want 0/0", out_if.out_valid, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    lo_idx = 5'd0;
    hi_idx = 5'd0;
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = N'(i * 32'h11);
    regs[0] = 32'hFFFF_FFFF;

    test_reset();
    test_full();
    test_stall();
    test_snapshot();
    regs[9] = N'(9 * 32'h11);
    @(negedge clk);
    test_err();
    test_abort();
    @(negedge clk);
    test_busy_start_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
